// File: rtl/sm_uart_tx.sv
// Bus-programmable UART transmitter: 8N1 framing, TX byte FIFO, runtime baud divisor.
// Divisor is latched per frame so DIVISOR writes only affect the next frame.
module sm_uart_tx #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd434
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bSel,
   input  logic [31:0] bAddr,
   input  logic        bWrite,
   input  logic [31:0] bWData,
   output logic [31:0] bRData,
   output logic        txd
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   state_e        state_q;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [4:0]    count_q;
   logic [4:0]    count_d;
   logic          ovf_q;
   logic          ovf_d;
   logic [15:0]   div_q;
   logic [15:0]   div_lat_q;
   logic [15:0]   baud_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          txd_q;

   logic wr_data;
   logic wr_status;
   logic wr_div;
   logic full;
   logic empty;
   logic busy;
   logic bit_end;
   logic pop;
   logic push;
   logic ovf_evt;

   logic unused_bits;
   assign unused_bits = ^{bAddr[31:4], bAddr[1:0], bWData[31:16]};

   always_comb begin
      wr_data   = bSel & bWrite & (bAddr[3:2] == 2'd0);
      wr_status = bSel & bWrite & (bAddr[3:2] == 2'd1);
      wr_div    = bSel & bWrite & (bAddr[3:2] == 2'd2);
      full      = (count_q == 5'(FIFO_DEPTH));
      empty     = (count_q == '0);
      busy      = (state_q != S_IDLE);
      // A latched divisor of 0 or 1 both end every bit after one cycle.
      bit_end   = ((baud_q + 16'd1) >= div_lat_q);
      pop       = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));
      push      = wr_data && (!full || pop);
      ovf_evt   = wr_data && full && !pop;

      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 5'd1;
      end else if (pop && !push) begin
         count_d = count_q - 5'd1;
      end

      ovf_d = ovf_q;
      if (ovf_evt) begin
         ovf_d = 1'b1;
      end else if (wr_status && bWData[3]) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bWData[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         div_q    <= DIV_RESET;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_d;
         ovf_q   <= ovf_d;
         if (wr_div) begin
            div_q <= bWData[15:0];
         end
      end
   end

   // txd is the registered line level of the current state, one cycle behind it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         txd_q     <= 1'b1;
         baud_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         div_lat_q <= '0;
      end else begin
         txd_q <= (state_q == S_START) ? 1'b0 :
                  (state_q == S_DATA)  ? shift_q[0] : 1'b1;
         unique case (state_q)
            S_IDLE: begin
               if (pop) begin
                  state_q   <= S_START;
                  shift_q   <= mem_q[rd_ptr_q];
                  div_lat_q <= div_q;
                  baud_q    <= '0;
               end
            end
            S_START: begin
               if (bit_end) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  state_q <= S_DATA;
               end else begin
                  baud_q <= baud_q + 16'd1;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  baud_q  <= '0;
                  shift_q <= {1'b0, shift_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     state_q <= S_STOP;
                  end
               end else begin
                  baud_q <= baud_q + 16'd1;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  baud_q <= '0;
                  if (pop) begin
                     state_q   <= S_START;
                     shift_q   <= mem_q[rd_ptr_q];
                     div_lat_q <= div_q;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else begin
                  baud_q <= baud_q + 16'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign txd = txd_q;

   always_comb begin
      bRData = '0;
      case (bAddr[3:2])
         2'd1:    bRData = {23'd0, count_q, ovf_q, empty, full, busy};
         2'd2:    bRData = {16'd0, div_q};
         default: bRData = '0;
      endcase
   end

endmodule

// File: tb/tb_sm_uart_tx.sv
// Self-checking bench for sm_uart_tx: register table, serial-line receiver model,
// hand-timed FIFO/overflow/reset sequences and randomized frames.
module tb_sm_uart_tx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        bSel;
   logic [31:0] bAddr;
   logic        bWrite;
   logic [31:0] bWData;
   logic [31:0] bRData;
   logic        txd;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sm_uart_tx #(.FIFO_DEPTH(4), .DIV_RESET(16'd434)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bSel   (bSel),
      .bAddr  (bAddr),
      .bWrite (bWrite),
      .bWData (bWData),
      .bRData (bRData),
      .txd    (txd)
   );

   typedef struct {
      logic        sel;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs [12];
   logic [7:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
      end
   endtask

   // Starts at a falling edge; the write is taken on the following rising edge.
   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      bSel   = 1'b1;
      bWrite = 1'b1;
      bAddr  = addr;
      bWData = data;
      @(negedge clk);
      bSel   = 1'b0;
      bWrite = 1'b0;
   endtask

   task automatic read_reg(input logic [31:0] addr, output logic [31:0] data);
      bAddr = addr;
      #1;
      data = bRData;
   endtask

   // Line receiver: finds the start bit, then requires each of the 10 bits to be
   // stable for exactly eff samples.
   task automatic recv_frame(input logic [7:0] exp, input int unsigned eff, input string name);
      int unsigned waited = 0;
      logic [9:0]  bits = '0;
      logic        ok = 1'b1;
      @(negedge clk);
      while (txd !== 1'b0 && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      if (txd !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL %s: no start bit before timeout, got txd=%b, expected 0", name, txd);
         return;
      end
      for (int b = 0; b < 10; b++) begin
         for (int unsigned s = 0; s < eff; s++) begin
            if (!(b == 0 && s == 0)) @(negedge clk);
            if (s == 0) bits[b] = txd;
            else if (txd !== bits[b]) ok = 1'b0;
         end
      end
      check(name, {21'd0, ok, bits}, {21'd0, 1'b1, 1'b1, exp, 1'b0});
   endtask

   task automatic idle_check(input int n, input string name);
      logic ok = 1'b1;
      repeat (n) begin
         @(negedge clk);
         if (txd !== 1'b1) ok = 1'b0;
      end
      check(name, {31'd0, ok}, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [9:0]  frame10;
      int          nerr;
      int unsigned div;
      int unsigned eff;
      int unsigned n;

      rst_n  = 1'b0;
      bSel   = 1'b0;
      bWrite = 1'b0;
      bAddr  = '0;
      bWData = '0;
      repeat (3) @(negedge clk);
      check("txd_in_reset", {31'd0, txd}, 32'd1);
      rst_n = 1'b1;

      vecs[0]  = '{1'b1, 1'b0, 32'h4,         32'h0,         32'h4,    "status_reset"};
      vecs[1]  = '{1'b1, 1'b0, 32'h8,         32'h0,         32'd434,  "div_reset"};
      vecs[2]  = '{1'b0, 1'b0, 32'h8,         32'h0,         32'd434,  "div_read_nosel"};
      vecs[3]  = '{1'b1, 1'b0, 32'h0,         32'h77,        32'h0,    "data_reads_zero"};
      vecs[4]  = '{1'b1, 1'b0, 32'hC,         32'h0,         32'h0,    "reserved_read"};
      vecs[5]  = '{1'b1, 1'b1, 32'h8,         32'hABCD1234,  32'h1234, "div_write_zext"};
      vecs[6]  = '{1'b0, 1'b1, 32'h8,         32'h5555,      32'h1234, "div_write_nosel"};
      vecs[7]  = '{1'b1, 1'b1, 32'hFFFFFFF8,  32'h000000A0,  32'hA0,   "div_write_addr_decode"};
      vecs[8]  = '{1'b1, 1'b1, 32'hC,         32'hFFFFFFFF,  32'h0,    "reserved_write"};
      vecs[9]  = '{1'b1, 1'b1, 32'h4,         32'hFFFFFFFF,  32'h4,    "status_write_noeffect"};
      vecs[10] = '{1'b1, 1'b1, 32'h8,         32'h0,         32'h0,    "div_write_zero"};
      vecs[11] = '{1'b1, 1'b0, 32'h4,         32'h0,         32'h4,    "status_no_push"};

      foreach (vecs[i]) begin
         @(negedge clk);
         bSel   = vecs[i].sel;
         bWrite = vecs[i].wr;
         bAddr  = vecs[i].addr;
         bWData = vecs[i].wdata;
         @(negedge clk);
         bSel   = 1'b0;
         bWrite = 1'b0;
         #1;
         check(vecs[i].name, bRData, vecs[i].exp);
      end

      // 0xA5 at divisor 4: exact line waveform and first-fall latency
      @(negedge clk);
      bus_write(32'h8, 32'd4);
      bus_write(32'h0, 32'hA5);
      @(negedge clk);
      check("txd_high_one_edge_after_write", {31'd0, txd}, 32'd1);
      frame10 = {1'b1, 8'hA5, 1'b0};
      nerr = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (txd !== frame10[i / 4]) nerr++;
      end
      check("frame_A5_bad_samples", nerr, 0);
      read_reg(32'h4, rd);
      check("idle_after_40_cycles", rd, 32'h4);

      // FIFO fill, overflow drop and sticky-bit clear at divisor 2
      @(negedge clk);
      bus_write(32'h8, 32'd2);
      exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      fork
         begin
            bus_write(32'h0, 32'h11);
            bus_write(32'h0, 32'h22);
            bus_write(32'h0, 32'h33);
            bus_write(32'h0, 32'h44);
            bus_write(32'h0, 32'h55);
            read_reg(32'h4, rd);
            check("status_full", rd, 32'h43);
            bus_write(32'h0, 32'h66);
            read_reg(32'h4, rd);
            check("status_overflow", rd, 32'h4B);
            bus_write(32'h4, 32'h8);
            read_reg(32'h4, rd);
            check("overflow_cleared", rd, 32'h43);
            bus_write(32'h0, 32'h77);
            read_reg(32'h4, rd);
            check("overflow_reset_by_drop", rd, 32'h4B);
            bus_write(32'h4, 32'h8);
         end
         begin
            while (exp_q.size() > 0) recv_frame(exp_q.pop_front(), 2, "ovf_frame");
         end
      join
      idle_check(40, "dropped_bytes_not_sent");
      read_reg(32'h4, rd);
      check("status_after_ovf_test", rd, 32'h4);

      // Push into a full FIFO on the same edge as the STOP-end pop (divisor 0)
      @(negedge clk);
      bus_write(32'h8, 32'd0);
      exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      fork
         begin
            bus_write(32'h0, 32'h01);
            bus_write(32'h0, 32'h02);
            bus_write(32'h0, 32'h03);
            bus_write(32'h0, 32'h04);
            bus_write(32'h0, 32'h05);
            repeat (6) @(negedge clk);
            bus_write(32'h0, 32'h06);
            read_reg(32'h4, rd);
            check("push_pop_when_full", rd, 32'h43);
         end
         begin
            while (exp_q.size() > 0) recv_frame(exp_q.pop_front(), 1, "full_pushpop_frame");
         end
      join

      // 0x00 at divisor 0: one cycle per bit, idle right after the stop bit
      @(negedge clk);
      bus_write(32'h0, 32'h00);
      recv_frame(8'h00, 1, "div0_frame_00");
      read_reg(32'h4, rd);
      check("div0_frame_10_cycles", rd, 32'h4);

      // Divisor change mid-frame only affects the next frame
      @(negedge clk);
      bus_write(32'h8, 32'd4);
      fork
         begin
            bus_write(32'h0, 32'h3C);
            repeat (10) @(negedge clk);
            bus_write(32'h8, 32'd8);
            bus_write(32'h0, 32'hC3);
         end
         begin
            recv_frame(8'h3C, 4, "old_div_frame");
            recv_frame(8'hC3, 8, "new_div_frame");
         end
      join

      // Reset during DATA bit 3 with a byte still queued
      @(negedge clk);
      bus_write(32'h8, 32'd4);
      bus_write(32'h0, 32'h00);
      bus_write(32'h0, 32'hFF);
      repeat (17) @(negedge clk);
      check("mid_frame_txd_low", {31'd0, txd}, 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      check("txd_high_at_reset_edge", {31'd0, txd}, 32'd1);
      read_reg(32'h4, rd);
      check("status_after_reset", rd, 32'h4);
      read_reg(32'h8, rd);
      check("div_after_reset", rd, 32'd434);
      rst_n = 1'b1;
      idle_check(60, "queue_discarded_by_reset");

      // Randomized bursts against the line-level model: bit time is max(div,1)
      for (int it = 0; it < 10; it++) begin
         div = $urandom_range(0, 5);
         eff = (div == 0) ? 1 : div;
         n   = $urandom_range(1, 4);
         exp_q.delete();
         for (int unsigned k = 0; k < n; k++) exp_q.push_back(8'($urandom));
         @(negedge clk);
         bus_write(32'h8, div);
         fork
            begin
               for (int unsigned k = 0; k < n; k++) bus_write(32'h0, {24'd0, exp_q[k]});
            end
            begin
               for (int unsigned k = 0; k < n; k++) recv_frame(exp_q[k], eff, "rand_frame");
            end
         join
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      read_reg(32'h4, rd);
      check("status_after_random", rd, 32'h4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
